// File: rtl/mult_pkg.sv
// Shared constants and helpers for the mult_pipe datapath: product width,
// internal extension width and saturation bounds.
package mult_pkg;

  localparam int unsigned MIN_STAGES = 2;

  function automatic int unsigned prod_w(int unsigned wa, int unsigned wb);
    return wa + wb;
  endfunction

  // Working width for the saturation compare: wide enough for both the
  // rounded product and the output range, plus sign and headroom.
  function automatic int unsigned ext_w(int unsigned win, int unsigned wp);
    return ((win > wp) ? win : wp) + 2;
  endfunction

  function automatic longint sat_max(int unsigned wp, bit sgn);
    return sgn ? (longint'(1) <<< (wp - 1)) - 1 : (longint'(1) <<< wp) - 1;
  endfunction

  function automatic longint sat_min(int unsigned wp, bit sgn);
    return sgn ? -(longint'(1) <<< (wp - 1)) : longint'(0);
  endfunction

endpackage

// File: rtl/mult_round_sat.sv
// Combinational round-half-up right shift of a full-width product followed
// by clipping to the WP-bit output range, with a clip flag.
module mult_round_sat
  import mult_pkg::*;
#(
  parameter int unsigned WIN    = 19,
  parameter int unsigned WP     = 19,
  parameter int unsigned SHIFT  = 0,
  parameter int unsigned SIGNED = 1
) (
  input  logic [WIN-1:0] prod_in,
  output logic [WP-1:0]  p_out,
  output logic           sat_out
);

  localparam int unsigned WE  = ext_w(WIN, WP);
  localparam int unsigned RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [WIN:0] RND = (SHIFT > 0) ? ((WIN + 1)'(1) << RSH) : '0;
  localparam logic signed [WE-1:0] MAXV = WE'(sat_max(WP, SIGNED != 0));
  localparam logic signed [WE-1:0] MINV = WE'(sat_min(WP, SIGNED != 0));

  logic [WIN:0]          ext;
  logic [WIN:0]          sum;
  logic [WIN:0]          shf;
  logic signed [WE-1:0]  wide;

  always_comb begin
    // One extra bit keeps the rounding add from wrapping.
    ext = (SIGNED != 0) ? {prod_in[WIN-1], prod_in} : {1'b0, prod_in};
    sum = ext + RND;
    if (SIGNED != 0) begin
      shf = $signed(sum) >>> SHIFT;
    end else begin
      shf = sum >> SHIFT;
    end
    wide = (SIGNED != 0) ? {{(WE - WIN - 1){shf[WIN]}}, shf}
                         : {{(WE - WIN - 1){1'b0}}, shf};
    sat_out = 1'b0;
    p_out   = wide[WP-1:0];
    if (wide > MAXV) begin
      p_out   = MAXV[WP-1:0];
      sat_out = 1'b1;
    end else if (wide < MINV) begin
      p_out   = MINV[WP-1:0];
      sat_out = 1'b1;
    end
  end

endmodule

// File: rtl/mult_pipe.sv
// Pipelined fixed-point multiplier with valid/ready flow control, optional
// product retiming stages, rounding shift and output saturation.
module mult_pipe
  import mult_pkg::*;
#(
  parameter int unsigned WA     = 10,
  parameter int unsigned WB     = 9,
  parameter int unsigned WP     = 19,
  parameter int unsigned SIGNED = 1,
  parameter int unsigned SHIFT  = 0,
  parameter int unsigned STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WA-1:0] a_in,
  input  logic [WB-1:0] b_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WP-1:0] p_out,
  output logic          sat_out
);

  localparam int unsigned WIN = prod_w(WA, WB);

  if (STAGES < MIN_STAGES) begin : g_bad_stages
    $error("mult_pipe: STAGES must be at least 2");
  end

  logic              en;
  logic [STAGES-1:0] vld_q, vld_d;
  logic [WA-1:0]     a_q, a_d;
  logic [WB-1:0]     b_q, b_d;
  logic [WIN-1:0]    a_x, b_x;
  logic [WIN-1:0]    prod_d;
  logic [WIN-1:0]    rs_in;
  logic [WP-1:0]     rs_p;
  logic              rs_sat;
  logic [WP-1:0]     p_q, p_d;
  logic              sat_q, sat_d;

  // A single enable stalls every stage together; bubbles are kept in place.
  always_comb begin
    en        = !vld_q[STAGES-1] || out_ready;
    in_ready  = en;
    out_valid = vld_q[STAGES-1];
    p_out     = p_q;
    sat_out   = sat_q;
  end

  always_comb begin
    vld_d = vld_q;
    a_d   = a_q;
    b_d   = b_q;
    if (en) begin
      vld_d = {vld_q[STAGES-2:0], in_valid};
      a_d   = a_in;
      b_d   = b_in;
    end
  end

  // Extending both operands to full product width lets one unsigned
  // multiply serve both signed and unsigned modes.
  always_comb begin
    a_x    = (SIGNED != 0) ? {{WB{a_q[WA-1]}}, a_q} : {{WB{1'b0}}, a_q};
    b_x    = (SIGNED != 0) ? {{WA{b_q[WB-1]}}, b_q} : {{WA{1'b0}}, b_q};
    prod_d = a_x * b_x;
  end

  if (STAGES == 2) begin : g_direct
    always_comb rs_in = prod_d;
  end else begin : g_retime
    logic [WIN-1:0] pipe_q [STAGES-2];
    logic [WIN-1:0] pipe_d [STAGES-2];

    always_comb begin
      for (int unsigned i = 0; i < STAGES - 2; i++) begin
        pipe_d[i] = pipe_q[i];
      end
      if (en) begin
        pipe_d[0] = prod_d;
        for (int unsigned i = 1; i < STAGES - 2; i++) begin
          pipe_d[i] = pipe_q[i-1];
        end
      end
      rs_in = pipe_q[STAGES-3];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < STAGES - 2; i++) begin
          pipe_q[i] <= '0;
        end
      end else begin
        for (int unsigned i = 0; i < STAGES - 2; i++) begin
          pipe_q[i] <= pipe_d[i];
        end
      end
    end
  end

  mult_round_sat #(
    .WIN    (WIN),
    .WP     (WP),
    .SHIFT  (SHIFT),
    .SIGNED (SIGNED)
  ) u_round_sat (
    .prod_in (rs_in),
    .p_out   (rs_p),
    .sat_out (rs_sat)
  );

  always_comb begin
    p_d   = en ? rs_p : p_q;
    sat_d = en ? rs_sat : sat_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      p_q   <= '0;
      sat_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      a_q   <= a_d;
      b_q   <= b_d;
      p_q   <= p_d;
      sat_q <= sat_d;
    end
  end

endmodule

// File: tb/tb_mult_pipe.sv
// Scoreboard bench for mult_pipe across four parameter sets: directed vectors,
// stall stream, mid-stream reset and a randomised handshake run.
`timescale 1ns/1ps
module tb_mult_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] iv   = '0;
  logic [3:0] ordy = '0;
  logic [9:0] av [4];
  logic [8:0] bv [4];
  wire  [3:0] ir, ov, sat;
  wire  [18:0] p0;
  wire  [15:0] p1, p2;
  wire  [7:0]  p3;

  mult_pipe #(.WA(10), .WB(9), .WP(19), .SIGNED(1), .SHIFT(0), .STAGES(2)) u_d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .a_in(av[0]), .b_in(bv[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .p_out(p0), .sat_out(sat[0]));
  mult_pipe #(.WA(10), .WB(9), .WP(16), .SIGNED(1), .SHIFT(0), .STAGES(4)) u_d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .a_in(av[1]), .b_in(bv[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .p_out(p1), .sat_out(sat[1]));
  mult_pipe #(.WA(10), .WB(9), .WP(16), .SIGNED(0), .SHIFT(4), .STAGES(3)) u_d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .a_in(av[2]), .b_in(bv[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]), .p_out(p2), .sat_out(sat[2]));
  mult_pipe #(.WA(10), .WB(9), .WP(8), .SIGNED(1), .SHIFT(4), .STAGES(2)) u_d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[3]), .in_ready(ir[3]), .a_in(av[3]), .b_in(bv[3]),
    .out_valid(ov[3]), .out_ready(ordy[3]), .p_out(p3), .sat_out(sat[3]));

  typedef struct {
    int p;
    bit s;
    int acc;
    bit lat;
  } exp_t;

  exp_t sb [4][$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   lat_of [4] = '{1, 3, 2, 1};
  bit   held_v [4];
  int   held_p [4];
  bit   held_s [4];
  exp_t mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int pval(int id);
    case (id)
      0:       return int'($signed(p0));
      1:       return int'($signed(p1));
      2:       return int'(p2);
      default: return int'($signed(p3));
    endcase
  endfunction

  task automatic chk(bit ok, string nm, int act, int exp_v);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp_v, $time);
    end
  endtask

  // Monitor: samples on the falling edge, pops the scoreboard on each output transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) held_v[i] = 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        chk(ir[i] == !(ov[i] && !ordy[i]), $sformatf("in_ready_d%0d", i),
            int'(ir[i]), int'(!(ov[i] && !ordy[i])));
        if (held_v[i]) begin
          chk(ov[i], $sformatf("hold_valid_d%0d", i), int'(ov[i]), 1);
          chk(pval(i) == held_p[i], $sformatf("hold_p_d%0d", i), pval(i), held_p[i]);
          chk(sat[i] == held_s[i], $sformatf("hold_sat_d%0d", i), int'(sat[i]), int'(held_s[i]));
        end
        if (ov[i] && ordy[i]) begin
          if (sb[i].size() == 0) begin
            chk(1'b0, $sformatf("unexpected_out_d%0d", i), pval(i), 0);
          end else begin
            mon_e = sb[i].pop_front();
            chk(pval(i) == mon_e.p, $sformatf("p_out_d%0d", i), pval(i), mon_e.p);
            chk(sat[i] == mon_e.s, $sformatf("sat_out_d%0d", i), int'(sat[i]), int'(mon_e.s));
            if (mon_e.lat)
              chk(cyc - mon_e.acc == lat_of[i], $sformatf("latency_d%0d", i),
                  cyc - mon_e.acc, lat_of[i]);
          end
        end
        held_v[i] = ov[i] && !ordy[i];
        held_p[i] = pval(i);
        held_s[i] = sat[i];
      end
    end
  end

  task automatic send(int id, int a, int b, int ep, bit es, bit lat);
    exp_t e;
    int   t;
    av[id] = 10'(a);
    bv[id] = 9'(b);
    iv[id] = 1'b1;
    for (t = 0; t < 64; t++) begin
      @(negedge clk);
      if (ir[id]) begin
        e.p = ep; e.s = es; e.acc = cyc + 1; e.lat = lat;
        sb[id].push_back(e);
        break;
      end
      @(posedge clk); #1;
    end
    if (t == 64) chk(1'b0, $sformatf("accept_timeout_d%0d", id), t, 0);
    @(posedge clk); #1;
    iv[id] = 1'b0;
  endtask

  task automatic drain(int id);
    for (int t = 0; t < 200 && sb[id].size() != 0; t++) begin
      @(posedge clk); #1;
    end
    chk(sb[id].size() == 0, $sformatf("drain_d%0d", id), sb[id].size(), 0);
  endtask

  initial begin
    bit pend;
    int ra, rb, v, ep;
    bit es;
    exp_t e;
    for (int i = 0; i < 4; i++) begin av[i] = '0; bv[i] = '0; end
    ordy = '1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      chk(ov[i] == 1'b0, $sformatf("rst_valid_d%0d", i), int'(ov[i]), 0);
      chk(ir[i] == 1'b1, $sformatf("rst_ready_d%0d", i), int'(ir[i]), 1);
      chk(pval(i) == 0, $sformatf("rst_p_d%0d", i), pval(i), 0);
      chk(sat[i] == 1'b0, $sformatf("rst_sat_d%0d", i), int'(sat[i]), 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Default configuration, back-to-back, no backpressure.
    send(0, -512, -256, 131072, 0, 1);
    send(0, 3, 5, 15, 0, 1);
    send(0, -512, 255, -130560, 0, 1);
    send(0, 511, 255, 130305, 0, 1);
    send(0, 0, -256, 0, 0, 1);
    drain(0);

    // Unsigned, SHIFT=4: rounding half up.
    send(2, 1023, 511, 32672, 0, 1);
    send(2, 3, 5, 1, 0, 1);
    send(2, 3, 2, 0, 0, 1);
    send(2, 24, 1, 2, 0, 1);
    send(2, 8, 1, 1, 0, 1);
    send(2, 7, 1, 0, 0, 1);
    drain(2);

    // Signed, SHIFT=4, WP=8: rounding toward +inf and clipping edges.
    send(3, 3, 5, 1, 0, 1);
    send(3, 3, 2, 0, 0, 1);
    send(3, -3, 5, -1, 0, 1);
    send(3, -8, 1, 0, 0, 1);
    send(3, -9, 1, -1, 0, 1);
    send(3, 511, 255, 127, 1, 1);
    send(3, -512, 255, -128, 1, 1);
    send(3, 127, 16, 127, 0, 1);
    send(3, 128, 16, 127, 1, 1);
    send(3, -128, 16, -128, 0, 1);
    drain(3);

    // STAGES=4, WP=16: eight pairs while out_ready toggles 1,0,0,1,0,0,...
    fork
      begin
        send(1, -512, -256, 32767, 1, 0);
        send(1, -512, 255, -32768, 1, 0);
        send(1, 100, 100, 10000, 0, 0);
        send(1, -3, 5, -15, 0, 0);
        send(1, 511, 64, 32704, 0, 0);
        send(1, 256, 128, 32767, 1, 0);
        send(1, -256, 128, -32768, 0, 0);
        send(1, -257, 128, -32768, 1, 0);
      end
      begin
        for (int k = 0; k < 40; k++) begin
          ordy[1] = (k % 3 == 0);
          @(posedge clk); #1;
        end
        ordy[1] = 1'b1;
      end
    join
    drain(1);

    // Fill the pipe under backpressure, then reset mid-stream.
    ordy[1] = 1'b0;
    for (int k = 0; k < 4; k++) send(1, k + 1, 2, 2 * (k + 1), 0, 0);
    chk(ov[1] == 1'b1, "fill_valid_d1", int'(ov[1]), 1);
    rst_n = 1'b0;
    #1;
    chk(ov[1] == 1'b0, "midrst_valid_d1", int'(ov[1]), 0);
    chk(pval(1) == 0, "midrst_p_d1", pval(1), 0);
    chk(sat[1] == 1'b0, "midrst_sat_d1", int'(sat[1]), 0);
    chk(ir[1] == 1'b1, "midrst_ready_d1", int'(ir[1]), 1);
    sb[1].delete();
    ordy[1] = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk(ov[1] == 1'b0, "no_stale_d1", int'(ov[1]), 0);

    // Random handshakes on the saturating configuration.
    pend = 1'b0;
    ra = 0;
    rb = 0;
    for (int c = 0; c < 400; c++) begin
      ordy[1] = ($urandom_range(0, 3) != 0);
      if (!pend && $urandom_range(0, 3) != 0) begin
        ra = int'($urandom_range(0, 1023)) - 512;
        rb = int'($urandom_range(0, 511)) - 256;
        pend = 1'b1;
      end
      iv[1] = pend;
      av[1] = 10'(ra);
      bv[1] = 9'(rb);
      @(negedge clk);
      if (pend && ir[1]) begin
        v = ra * rb;
        if (v > 32767)       begin ep = 32767;  es = 1'b1; end
        else if (v < -32768) begin ep = -32768; es = 1'b1; end
        else                 begin ep = v;      es = 1'b0; end
        e.p = ep; e.s = es; e.acc = cyc + 1; e.lat = 1'b0;
        sb[1].push_back(e);
        pend = 1'b0;
      end
      @(posedge clk); #1;
    end
    iv[1] = 1'b0;
    ordy[1] = 1'b1;
    drain(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
